vga_fb_renderer: RTL and testbench
==================================

Name: vga_fb_renderer

Overview:
- Pixel stage directly downstream of the VGA timing scanner; consumes its hs/vs/en/x/y (100 MHz domain, each pixel held 4 clk).
- Fetches 12-bit colour from a scaled framebuffer held in an external synchronous RAM and overlays a square hardware cursor.
- Drives RGB to the pins with hs/vs delay-matched to the colour.
- Cursor registers are CPU-writable and double-buffered so updates take effect only at frame boundaries.

Parameters:
- FB_W, 160, framebuffer width in cells
- FB_H, 120, framebuffer height in cells
- SCALE_LOG2, 2, display pixels per cell edge = 2**SCALE_LOG2
- ADDR_W, 15, framebuffer address width (must satisfy 2**ADDR_W >= FB_W*FB_H)
- CUR_SIZE, 8, cursor square edge in display pixels

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- hs_in  in  1  scanner hsync, active low
- vs_in  in  1  scanner vsync, active low
- en_in  in  1  scanner active-video flag
- x_in  in  16  scanner column, 0 when en_in=0
- y_in  in  16  scanner row, 0 when en_in=0
- fb_addr  out  ADDR_W  framebuffer read address
- fb_data  in  12  RAM read data {R4,G4,B4}, valid 1 clk after fb_addr
- cur_we  in  1  cursor register write strobe
- cur_x  in  16  cursor left column (display pixels)
- cur_y  in  16  cursor top row
- cur_color  in  12  cursor colour
- cur_show  in  1  cursor enable
- hs  out  1  delayed hsync
- vs  out  1  delayed vsync
- rgb  out  12  pixel colour {R,G,B}
- frame_start  out  1  1-clk pulse at the commit edge

Behaviour:
- Reset:
  - hs=1, vs=1, rgb=0, fb_addr=0, frame_start=0.
  - Shadow and active cursor registers cleared (show=0).
  - Pipeline valid bits cleared.
  - A reset mid-frame simply restarts the pipeline; the first 3 clk after reset output blank with hs=vs=1.
- Pipeline, fixed latency 3 clk from inputs to hs/vs/rgb; every clk advances, no stalls:
  - S1: register hs_in, vs_in, en_in, x_in, y_in. Compute cx = x>>SCALE_LOG2, cy = y>>SCALE_LOG2, inrange = en && cx<FB_W && cy<FB_H. Compute cursor hit.
  - fb_addr is registered from S1: cy*FB_W+cx when inrange, else 0. Multiply by the constant FB_W is truncated to ADDR_W.
  - S2: RAM returns fb_data; delay hs/vs/en/inrange/hit one further stage.
  - S3 output register:
    - rgb = hit ? active cur_color : (inrange ? fb_data : 0).
    - rgb = 0 whenever the delayed en = 0, including during sync.
- Cursor hit:
  - hit = en && active_show && x>=active_x && x<active_x+CUR_SIZE && y>=active_y && y<active_y+CUR_SIZE.
  - Sums computed in 17 bits, so no wrap at 16'hFFFF.
  - A cursor partly off-screen shows only its on-screen part.
- Double buffering:
  - cur_we=1 loads all four shadow registers on that clk.
  - Commit edge: S1 vs sees a 1->0 transition (start of vsync pulse). On that clk, active <= shadow.
  - A cur_we on the same clk as the commit writes shadow only. The commit uses the pre-write shadow, and the new value lands next frame.
  - frame_start is asserted the clk after the commit edge for exactly 1 clk.
- Boundaries:
  - If display area exceeds FB_W*2^S by FB_H*2^S, the excess area is black.
  - x=639,y=479 maps to addr 19199 with defaults.

Decomposition:
- Shared package vga_pkg:
  - timing constants (HD=640, VD=480 and porch/sync values)
  - COLOR_W=12
  - rgb field slice localparams
- One sub-module, vga_cursor_regs: shadow/active registers, commit-edge detect, frame_start, and the hit comparator. The renderer instantiates it once.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst for 2 clk with x_in=100.
  - Required: hs=vs=1, rgb=0, fb_addr=0, frame_start=0 during reset and for 3 clk after release.
- Address mapping:
  - Stimulus: drive en_in=1, (x,y)=(13,9).
  - Required: fb_addr=2*160+3=323 on the next clk. RAM model returns 12'hABC and rgb=12'hABC 3 clk after the input.
- Blanking:
  - Stimulus: en_in=0 with fb_data=12'hFFF.
  - Required: rgb=0. hs/vs reproduce the input pattern delayed exactly 3 clk.
- Cursor overlay:
  - Stimulus: write cur_x=100, cur_y=50, color=12'hF00, show=1, then a vs_in falling edge.
  - Required:
    - frame_start pulses 1 clk.
    - Pixels (100,50) and (107,57) give rgb=12'hF00.
    - Pixels (108,50) and (99,50) give framebuffer data.
- Commit collision:
  - Stimulus: cur_we with cur_x=200 on the exact commit clk.
  - Required: active cursor remains at the old x for that frame, then moves to 200 after the next vs falling edge.
- Edge cursor:
  - Stimulus: cur_x=16'hFFFC, show=1.
  - Required: no hit anywhere on screen, which shows there is no 16-bit wrap.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and colour field layout
package vga_pkg;

   // 640x480 @ 60 Hz timing (display pixels)
   localparam int HD    = 640;
   localparam int HFP   = 16;
   localparam int HSYNC = 96;
   localparam int HBP   = 48;
   localparam int VD    = 480;
   localparam int VFP   = 10;
   localparam int VSYNC = 2;
   localparam int VBP   = 33;

   // Colour word {R4,G4,B4}
   localparam int COLOR_W = 12;
   localparam int R_MSB   = 11;
   localparam int R_LSB   = 8;
   localparam int G_MSB   = 7;
   localparam int G_LSB   = 4;
   localparam int B_MSB   = 3;
   localparam int B_LSB   = 0;

endpackage

// File: rtl/vga_fb_renderer_if.sv
// rtl/vga_fb_renderer_if.sv - scanner, framebuffer, cursor and pin signals of the renderer
// master: scanner/RAM/CPU side (drives *_in, fb_data, cur_*; receives fb_addr, hs, vs, rgb, frame_start)
// slave : renderer side
interface vga_fb_renderer_if #(
   parameter int ADDR_W = 15
);
   import vga_pkg::*;

   logic                hs_in;
   logic                vs_in;
   logic                en_in;
   logic [15:0]         x_in;
   logic [15:0]         y_in;
   logic [ADDR_W-1:0]   fb_addr;
   logic [COLOR_W-1:0]  fb_data;
   logic                cur_we;
   logic [15:0]         cur_x;
   logic [15:0]         cur_y;
   logic [COLOR_W-1:0]  cur_color;
   logic                cur_show;
   logic                hs;
   logic                vs;
   logic [COLOR_W-1:0]  rgb;
   logic                frame_start;

   modport master (
      output hs_in, vs_in, en_in, x_in, y_in, fb_data,
      output cur_we, cur_x, cur_y, cur_color, cur_show,
      input  fb_addr, hs, vs, rgb, frame_start
   );

   modport slave (
      input  hs_in, vs_in, en_in, x_in, y_in, fb_data,
      input  cur_we, cur_x, cur_y, cur_color, cur_show,
      output fb_addr, hs, vs, rgb, frame_start
   );

endinterface

// File: rtl/vga_cursor_regs.sv
// rtl/vga_cursor_regs.sv - double-buffered cursor registers, frame commit and hit test
// i_we/i_cur_*     : CPU shadow-register write
// i_vs             : scanner vsync (active low) as seen by stage 1
// i_en/i_x/i_y     : current scanner pixel
// o_hit            : pixel lies inside the active cursor square
// o_color          : active cursor colour
// o_frame_start    : 1-clk pulse the clk after the commit edge
module vga_cursor_regs
   import vga_pkg::*;
#(
   parameter int CUR_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_we,
   input  logic [15:0]        i_cur_x,
   input  logic [15:0]        i_cur_y,
   input  logic [COLOR_W-1:0] i_cur_color,
   input  logic               i_cur_show,
   input  logic               i_vs,
   input  logic               i_en,
   input  logic [15:0]        i_x,
   input  logic [15:0]        i_y,
   output logic               o_hit,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_frame_start
);

   logic [15:0]        r_sh_x;
   logic [15:0]        r_sh_y;
   logic [COLOR_W-1:0] r_sh_color;
   logic               r_sh_show;
   logic [15:0]        r_act_x;
   logic [15:0]        r_act_y;
   logic [COLOR_W-1:0] r_act_color;
   logic               r_act_show;
   logic               r_vs_prev;
   logic               r_frame_start;

   logic               w_commit;
   logic [16:0]        w_x_end;
   logic [16:0]        w_y_end;

   // Start of the vsync pulse; the active set is swapped exactly here
   assign w_commit = r_vs_prev & ~i_vs;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_x        <= '0;
         r_sh_y        <= '0;
         r_sh_color    <= '0;
         r_sh_show     <= 1'b0;
         r_act_x       <= '0;
         r_act_y       <= '0;
         r_act_color   <= '0;
         r_act_show    <= 1'b0;
         r_vs_prev     <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_vs_prev     <= i_vs;
         r_frame_start <= w_commit;
         // Commit copies the pre-write shadow; a same-clk write lands next frame
         if (w_commit) begin
            r_act_x     <= r_sh_x;
            r_act_y     <= r_sh_y;
            r_act_color <= r_sh_color;
            r_act_show  <= r_sh_show;
         end
         if (i_we) begin
            r_sh_x     <= i_cur_x;
            r_sh_y     <= i_cur_y;
            r_sh_color <= i_cur_color;
            r_sh_show  <= i_cur_show;
         end
      end
   end

   // 17-bit ends so a cursor near 16'hFFFF does not wrap onto column 0
   assign w_x_end = {1'b0, r_act_x} + 17'(CUR_SIZE);
   assign w_y_end = {1'b0, r_act_y} + 17'(CUR_SIZE);

   assign o_hit = i_en && r_act_show &&
                  (i_x >= r_act_x) && ({1'b0, i_x} < w_x_end) &&
                  (i_y >= r_act_y) && ({1'b0, i_y} < w_y_end);

   assign o_color       = r_act_color;
   assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_fb_renderer.sv
// rtl/vga_fb_renderer.sv - framebuffer pixel renderer with hardware cursor overlay
// clk/rst        : 100 MHz clock, synchronous active-high reset
// bus.*_in       : scanner hs/vs/en/x/y
// bus.fb_addr    : framebuffer read address (registered), bus.fb_data returns 1 clk later
// bus.cur_*      : cursor shadow-register write port
// bus.hs/vs/rgb  : pin outputs, 3 clk after the scanner inputs
// bus.frame_start: pulse following the cursor commit
module vga_fb_renderer
   import vga_pkg::*;
#(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 15,
   parameter int CUR_SIZE   = 8
) (
   input  logic              clk,
   input  logic              rst,
   vga_fb_renderer_if.slave  bus
);

   localparam logic [15:0] FB_W16 = 16'(FB_W);
   localparam logic [15:0] FB_H16 = 16'(FB_H);

   logic [15:0]        w_cx;
   logic [15:0]        w_cy;
   logic               w_inrange;
   logic [ADDR_W-1:0]  w_lin_addr;
   logic               w_hit;
   logic [COLOR_W-1:0] w_cur_color;

   // Stage 1
   logic               r1_hs;
   logic               r1_vs;
   logic               r1_en;
   logic               r1_inrange;
   logic               r1_hit;
   logic [ADDR_W-1:0]  r_fb_addr;
   // Stage 2 (aligned with the RAM read)
   logic               r2_hs;
   logic               r2_vs;
   logic               r2_en;
   logic               r2_inrange;
   logic               r2_hit;
   // Stage 3 (pins)
   logic               r_hs;
   logic               r_vs;
   logic [COLOR_W-1:0] r_rgb;

   assign w_cx      = bus.x_in >> SCALE_LOG2;
   assign w_cy      = bus.y_in >> SCALE_LOG2;
   // Display area beyond the scaled framebuffer renders black
   assign w_inrange = bus.en_in && (w_cx < FB_W16) && (w_cy < FB_H16);
   assign w_lin_addr = ADDR_W'(32'(w_cy) * 32'(FB_W) + 32'(w_cx));

   vga_cursor_regs #(
      .CUR_SIZE (CUR_SIZE)
   ) u_cursor (
      .clk           (clk),
      .rst           (rst),
      .i_we          (bus.cur_we),
      .i_cur_x       (bus.cur_x),
      .i_cur_y       (bus.cur_y),
      .i_cur_color   (bus.cur_color),
      .i_cur_show    (bus.cur_show),
      .i_vs          (bus.vs_in),
      .i_en          (bus.en_in),
      .i_x           (bus.x_in),
      .i_y           (bus.y_in),
      .o_hit         (w_hit),
      .o_color       (w_cur_color),
      .o_frame_start (bus.frame_start)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_hs      <= 1'b1;
         r1_vs      <= 1'b1;
         r1_en      <= 1'b0;
         r1_inrange <= 1'b0;
         r1_hit     <= 1'b0;
         r_fb_addr  <= '0;
         r2_hs      <= 1'b1;
         r2_vs      <= 1'b1;
         r2_en      <= 1'b0;
         r2_inrange <= 1'b0;
         r2_hit     <= 1'b0;
         r_hs       <= 1'b1;
         r_vs       <= 1'b1;
         r_rgb      <= '0;
      end else begin
         r1_hs      <= bus.hs_in;
         r1_vs      <= bus.vs_in;
         r1_en      <= bus.en_in;
         r1_inrange <= w_inrange;
         r1_hit     <= w_hit;
         r_fb_addr  <= w_inrange ? w_lin_addr : '0;

         r2_hs      <= r1_hs;
         r2_vs      <= r1_vs;
         r2_en      <= r1_en;
         r2_inrange <= r1_inrange;
         r2_hit     <= r1_hit;

         r_hs <= r2_hs;
         r_vs <= r2_vs;
         if (!r2_en)
            r_rgb <= '0;
         else if (r2_hit)
            r_rgb <= w_cur_color;
         else if (r2_inrange)
            r_rgb <= bus.fb_data;
         else
            r_rgb <= '0;
      end
   end

   assign bus.fb_addr = r_fb_addr;
   assign bus.hs      = r_hs;
   assign bus.vs      = r_vs;
   assign bus.rgb     = r_rgb;

endmodule

// File: tb/tb_vga_fb_renderer.sv
// tb/tb_vga_fb_renderer.sv - randomized self-checking bench for vga_fb_renderer
module tb_vga_fb_renderer;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_fb_renderer_if #(.ADDR_W(15)) bus ();

   vga_fb_renderer #(
      .FB_W(160), .FB_H(120), .SCALE_LOG2(2), .ADDR_W(15), .CUR_SIZE(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous framebuffer RAM
   logic [11:0] mem [0:32767];
   always @(posedge clk) bus.fb_data <= mem[bus.fb_addr];

   // Reference model: cursor state and per-cycle expected outputs
   int          a_x, a_y, s_x, s_y;
   logic [11:0] a_c, s_c;
   bit          a_s, s_s, vs_prev;
   bit          e_hs [8];
   bit          e_vs [8];
   logic [11:0] e_rgb [8];
   int          e_addr [8];
   bit          e_fs [8];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          rnd_we = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clk: check the outputs due now, drive the next input set, update the model
   task automatic step(input bit r, h, v, e, input int xi, yi,
                       input bit we, input int wx, wy, input logic [11:0] wc, input bit ws);
      int x, y, cx, cy, ad;
      bit inr, hit, com;
      logic [11:0] col;
      @(negedge clk);
      if (cyc > 0) begin
         chk("hs",          32'(bus.hs),          32'(e_hs[cyc % 8]));
         chk("vs",          32'(bus.vs),          32'(e_vs[cyc % 8]));
         chk("rgb",         32'(bus.rgb),         32'(e_rgb[cyc % 8]));
         chk("fb_addr",     32'(bus.fb_addr),     32'(e_addr[cyc % 8]));
         chk("frame_start", 32'(bus.frame_start), 32'(e_fs[cyc % 8]));
      end
      x = xi & 32'hFFFF;
      y = yi & 32'hFFFF;
      rst           = r;
      bus.hs_in     = h;
      bus.vs_in     = v;
      bus.en_in     = e;
      bus.x_in      = 16'(x);
      bus.y_in      = 16'(y);
      bus.cur_we    = we;
      bus.cur_x     = 16'(wx);
      bus.cur_y     = 16'(wy);
      bus.cur_color = wc;
      bus.cur_show  = ws;
      if (r) begin
         for (int k = 1; k <= 3; k++) begin
            e_hs[(cyc + k) % 8]  = 1'b1;
            e_vs[(cyc + k) % 8]  = 1'b1;
            e_rgb[(cyc + k) % 8] = '0;
         end
         e_addr[(cyc + 1) % 8] = 0;
         e_fs[(cyc + 1) % 8]   = 1'b0;
         a_x = 0; a_y = 0; a_c = '0; a_s = 1'b0;
         s_x = 0; s_y = 0; s_c = '0; s_s = 1'b0;
         vs_prev = 1'b1;
      end else begin
         cx  = x / 4;
         cy  = y / 4;
         inr = e && cx < 160 && cy < 120;
         ad  = inr ? cy * 160 + cx : 0;
         hit = e && a_s && x >= a_x && x < a_x + 8 && y >= a_y && y < a_y + 8;
         col = !e ? 12'h000 : hit ? a_c : inr ? mem[ad] : 12'h000;
         e_hs[(cyc + 3) % 8]   = h;
         e_vs[(cyc + 3) % 8]   = v;
         e_rgb[(cyc + 3) % 8]  = col;
         e_addr[(cyc + 1) % 8] = ad;
         com = !v && vs_prev;
         e_fs[(cyc + 1) % 8]   = com;
         if (com) begin
            a_x = s_x; a_y = s_y; a_c = s_c; a_s = s_s;
         end
         vs_prev = v;
         if (we) begin
            s_x = wx & 32'hFFFF; s_y = wy & 32'hFFFF; s_c = wc; s_s = ws;
         end
      end
      cyc++;
   endtask

   task automatic rand_we(output bit we, output int wx, wy, output logic [11:0] wc, output bit ws);
      we = rnd_we && ($urandom % 6 == 0);
      wx = ($urandom % 10 == 0) ? 32'hFFFC : int'($urandom % 660);
      wy = int'($urandom % 500);
      wc = 12'($urandom);
      ws = ($urandom % 4) != 0;
   endtask

   task automatic pix(input int x, y);
      bit we, ws; int wx, wy; logic [11:0] wc;
      rand_we(we, wx, wy, wc, ws);
      step(1'b0, 1'b1, 1'b1, 1'b1, x, y, we, wx, wy, wc, ws);
   endtask

   task automatic blank(input bit h, v);
      bit we, ws; int wx, wy; logic [11:0] wc;
      rand_we(we, wx, wy, wc, ws);
      step(1'b0, h, v, 1'b0, 0, 0, we, wx, wy, wc, ws);
   endtask

   task automatic cur_write(input int wx, wy, input logic [11:0] wc, input bit ws);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, wx, wy, wc, ws);
   endtask

   task automatic vsync_frame();
      for (int i = 0; i < 4; i++) blank(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);
   endtask

   // Pixel followed by two blanks, then the rgb 3 clk after the input
   task automatic probe(input string tag, input int x, y, input logic [11:0] exp);
      pix(x, y);
      blank(1'b1, 1'b1);
      blank(1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk(tag, 32'(bus.rgb), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);
      mem[323] = 12'hABC;
      mem[0]   = 12'hFFF;
      bus.fb_data = '0;
      bus.hs_in = 1'b1; bus.vs_in = 1'b1; bus.en_in = 1'b0;
      bus.x_in = '0; bus.y_in = '0;
      bus.cur_we = 1'b0; bus.cur_x = '0; bus.cur_y = '0;
      bus.cur_color = '0; bus.cur_show = 1'b0;

      // Power-up reset, a few pixels, then reset mid-frame with x_in=100
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 12'h0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 12'h0, 1'b0);
      for (int i = 0; i < 5; i++) pix(int'($urandom % 640), int'($urandom % 480));
      step(1'b1, 1'b0, 1'b1, 1'b1, 100, 7, 1'b0, 0, 0, 12'h0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 100, 7, 1'b0, 0, 0, 12'h0, 1'b0);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);

      // Address mapping (13,9) -> 323
      pix(13, 9);
      @(posedge clk);
      #1;
      chk("addr_13_9", 32'(bus.fb_addr), 32'd323);
      blank(1'b1, 1'b1);
      blank(1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk("rgb_13_9", 32'(bus.rgb), 32'hABC);

      // Blanking with sync patterns, RAM word 0 = FFF
      for (int i = 0; i < 10; i++) blank(1'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) blank(1'b0, 1'b1);

      // Cursor overlay
      cur_write(100, 50, 12'hF00, 1'b1);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);
      blank(1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("frame_start", 32'(bus.frame_start), 32'd1);
      blank(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);
      probe("cur_100_50", 100, 50, 12'hF00);
      probe("cur_107_57", 107, 57, 12'hF00);
      probe("fb_108_50",  108, 50, mem[12 * 160 + 27]);
      probe("fb_99_50",   99,  50, mem[12 * 160 + 24]);

      // Commit collision: write cur_x=200 on the commit clk
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 200, 50, 12'h0F0, 1'b1);
      blank(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) blank(1'b1, 1'b1);
      probe("old_cur_100", 100, 50, 12'hF00);
      probe("new_cur_200_pending", 200, 50, mem[12 * 160 + 50]);
      vsync_frame();
      probe("new_cur_200", 200, 50, 12'h0F0);
      probe("old_cur_gone", 100, 50, mem[12 * 160 + 25]);

      // Edge cursor at 16'hFFFC: no wrap onto the screen
      cur_write(32'hFFFC, 0, 12'h00F, 1'b1);
      vsync_frame();
      probe("edge_0_0",     0,   0,   mem[0]);
      probe("edge_3_0",     3,   0,   mem[0]);
      probe("edge_639_0",   639, 0,   mem[159]);
      probe("last_cell",    639, 479, mem[19199]);
      probe("excess_640",   640, 0,   12'h000);
      probe("excess_y_480", 0,   480, 12'h000);

      // Randomized frames with random cursor writes
      rnd_we = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int row = 0; row < 10; row++) begin
            for (int p = 0; p < 12; p++) begin
               if ($urandom % 2 == 0)
                  pix(a_x - 2 + int'($urandom % 12), a_y - 2 + int'($urandom % 12));
               else
                  pix(int'($urandom % 720), int'($urandom % 520));
            end
            blank(1'b1, 1'b1);
            blank(1'b0, 1'b1);
            blank(1'b0, 1'b1);
            blank(1'b1, 1'b1);
         end
         vsync_frame();
      end
      rnd_we = 1'b0;
      for (int i = 0; i < 4; i++) blank(1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
